// File: rtl/pipeline_ctrl_if.sv
// Request/response bundle between the pipeline stages and the hazard scheduler.
// The scheduler sits on the slave side; the stage logic (or a bench) drives the master side.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             stallreq_if_i;
  logic             jbstallreq_i;
  logic             lwstallreq_i;
  logic             stallreq_ex_i;
  logic             stallreq_mem_i;
  logic [4:0]       stall_o;
  logic [4:0]       bubble_o;
  logic             timeout_o;
  logic [CNT_W-1:0] stall_cycles_o;

  modport master (
    output stallreq_if_i, jbstallreq_i, lwstallreq_i, stallreq_ex_i, stallreq_mem_i,
    input  stall_o, bubble_o, timeout_o, stall_cycles_o
  );

  modport slave (
    input  stallreq_if_i, jbstallreq_i, lwstallreq_i, stallreq_ex_i, stallreq_mem_i,
    output stall_o, bubble_o, timeout_o, stall_cycles_o
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/stall scheduler for the 5-stage pipeline: priority-arbitrates stage stall requests,
// sequences multi-cycle jump/branch bubbles, flags stuck EX/MEM stalls and counts stalled cycles.
module pipeline_ctrl #(
  parameter int JB_BUBBLES = 1,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 32
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
);

  localparam int JBW = 4;
  localparam int TOW = $clog2(TIMEOUT + 1);
  localparam logic [JBW-1:0] JB_RELOAD = JBW'(JB_BUBBLES - 1);
  localparam logic [TOW-1:0] TO_LAST   = TOW'(TIMEOUT - 1);
  localparam logic [TOW-1:0] TO_SAT    = TOW'(TIMEOUT);

  // Vector order: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB
  localparam logic [4:0] ST_MEM = 5'b01111, BU_MEM = 5'b10000;
  localparam logic [4:0] ST_EX  = 5'b00111, BU_EX  = 5'b01000;
  localparam logic [4:0] ST_LW  = 5'b00011, BU_LW  = 5'b00100;
  localparam logic [4:0] ST_JB  = 5'b00000, BU_JB  = 5'b00010;
  localparam logic [4:0] ST_IF  = 5'b00001, BU_IF  = 5'b00010;

  typedef enum logic {
    ST_RUN,
    ST_JBSEQ
  } state_t;

  state_t           state_q, state_d;
  logic [JBW-1:0]   jb_cnt_q, jb_cnt_d;
  logic [TOW-1:0]   to_cnt_q, to_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [4:0] stall, bubble;
  logic       hi_req;
  logic       jb_src;
  logic       exmem_req;

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    jb_cnt_q  <= jb_cnt_d;
    to_cnt_q  <= to_cnt_d;
    timeout_q <= timeout_d;
    cnt_q     <= cnt_d;
  end

  always_comb begin
    stall     = 5'b00000;
    bubble    = 5'b00000;
    state_d   = state_q;
    jb_cnt_d  = jb_cnt_q;
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    exmem_req = bus.stallreq_ex_i | bus.stallreq_mem_i;
    hi_req    = exmem_req | bus.lwstallreq_i;
    // An active JB sequence keeps bubbling IF/ID even after ID drops its request.
    jb_src    = bus.jbstallreq_i | (state_q == ST_JBSEQ);

    if (rst) begin
      bubble    = 5'b11111;
      state_d   = ST_RUN;
      jb_cnt_d  = '0;
      to_cnt_d  = '0;
      timeout_d = 1'b0;
      cnt_d     = '0;
    end else begin
      if (bus.stallreq_mem_i) begin
        stall  = ST_MEM;
        bubble = BU_MEM;
      end else if (bus.stallreq_ex_i) begin
        stall  = ST_EX;
        bubble = BU_EX;
      end else if (bus.lwstallreq_i) begin
        stall  = ST_LW;
        bubble = BU_LW;
      end else if (jb_src) begin
        stall  = ST_JB;
        bubble = BU_JB;
      end else if (bus.stallreq_if_i) begin
        stall  = ST_IF;
        bubble = BU_IF;
      end

      // Higher-priority stalls freeze the bubble sequence; LW beating JB leaves ID to re-present it.
      case (state_q)
        ST_RUN: begin
          if (!hi_req && bus.jbstallreq_i && (JB_BUBBLES > 1)) begin
            jb_cnt_d = JB_RELOAD;
            state_d  = ST_JBSEQ;
          end
        end
        ST_JBSEQ: begin
          if (!hi_req) begin
            if (bus.jbstallreq_i) begin
              jb_cnt_d = JB_RELOAD;
            end else begin
              jb_cnt_d = jb_cnt_q - 1'b1;
              if (jb_cnt_q == JBW'(1)) state_d = ST_RUN;
            end
          end
        end
        default: state_d = ST_RUN;
      endcase

      if (exmem_req) begin
        if (to_cnt_q == TO_LAST) timeout_d = 1'b1;
        if (to_cnt_q != TO_SAT)  to_cnt_d  = to_cnt_q + 1'b1;
      end else begin
        to_cnt_d = '0;
      end

      if (((stall != 5'b00000) || (bubble != 5'b00000)) && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Registered status is masked during reset so the reset view appears in the same cycle.
  assign bus.stall_o        = stall;
  assign bus.bubble_o       = bubble;
  assign bus.timeout_o      = timeout_q & ~rst;
  assign bus.stall_cycles_o = rst ? '0 : cnt_q;

endmodule
